slot_alloc: RTL
===============

SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the number of slots; W is a power of two and at least 2.
REQ-002 The block SHALL have an input i_clk, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have an input i_arst_n, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have an input i_any, 1 bit, the allocation policy: 1 = lowest free index, 0 = circular from the pointer.
REQ-005 The block SHALL have an input i_alloc_req, 1 bit, the allocation request.
REQ-006 The block SHALL have an output o_alloc_gnt, 1 bit, the allocation grant.
REQ-007 The block SHALL have an output o_alloc_id, $clog2(W) bits, the granted slot index, valid only when o_alloc_gnt=1.
REQ-008 The block SHALL have an input i_free_vld, 1 bit, the free strobe.
REQ-009 The block SHALL have an input i_free_id, $clog2(W) bits, the slot to release.
REQ-010 The block SHALL have an input i_flush, 1 bit, the synchronous release of all slots.
REQ-011 The block SHALL have an output o_busy, W bits, the registered occupancy vector.
REQ-012 The block SHALL have an output o_cnt, $clog2(W)+1 bits, the count of busy slots.
REQ-013 The block SHALL have outputs o_full and o_empty, 1 bit each, meaning o_cnt==W and o_cnt==0 respectively.
REQ-014 The block SHALL have an output o_err, 1 bit, a sticky illegal-free flag.

Function
REQ-015 o_alloc_gnt SHALL equal i_alloc_req & ~o_full & ~i_flush, combinationally from registered state, giving zero-cycle grant latency.
REQ-016 The candidate slot SHALL be the first zero of o_busy, searched as follows.
- i_any=1: from bit 0 upward.
- i_any=0: starting at bit (ptr-1) mod W, descending with wrap.
REQ-017 o_alloc_id SHALL be that candidate.
REQ-018 On a grant, o_busy[o_alloc_id] SHALL set at the next edge, and ptr SHALL load o_alloc_id.
REQ-019 ptr SHALL be updated only on a grant and SHALL be unchanged in both policies otherwise.
REQ-020 On i_free_vld with o_busy[i_free_id]=1, that bit SHALL clear at the next edge.
REQ-021 On i_free_vld with o_busy[i_free_id]=0, the request SHALL be ignored and o_err SHALL set and remain set until reset.
REQ-022 When a grant and a legal free occur in the same cycle, both SHALL take effect and o_cnt SHALL remain unchanged.
- The freed slot is not a grant candidate in that cycle.
REQ-023 A free and an allocation SHALL never target the same slot in one cycle, since a granted slot is not busy; no arbitration is required.
REQ-024 o_cnt SHALL increment on a grant without a legal free, decrement on a legal free without a grant, and otherwise hold.
REQ-025 o_cnt SHALL never wrap.
REQ-026 i_flush SHALL have priority over a same-cycle free, which is not checked for legality.
REQ-027 i_flush SHALL clear o_busy and o_cnt at the next edge, leave ptr and o_err unchanged, and suppress any grant that cycle.
REQ-028 When o_full=1, o_alloc_gnt SHALL be 0; a same-cycle free SHALL still be processed.

Reset
REQ-029 While i_arst_n=0, the outputs SHALL take these values irrespective of the clock:
- o_busy=0, o_cnt=0, ptr=0, o_err=0
- o_empty=1, o_full=0
REQ-030 o_alloc_gnt SHALL be 0 during reset.
REQ-031 Deassertion of reset SHALL require no initialisation cycles; the first grant is possible in the first clock after deassertion.
REQ-032 Reset asserted mid-operation SHALL discard all occupancy without reporting an error.

Structure
REQ-033 The circular first-zero search SHALL be an instance of the team's existing selector module s with the following connections:
- i_x=o_busy, i_pos=ptr, i_any=i_any
- o_y_enc drives o_alloc_id
REQ-034 No duplicate search logic SHALL exist.
REQ-035 A shared package SHALL hold the slot-id typedef (width $clog2(W)) and the count typedef (width $clog2(W)+1), for reuse by producers and consumers of slot ids.
REQ-036 Registers SHALL be o_busy, ptr, o_cnt and o_err only; o_full and o_empty SHALL be decoded from o_cnt.

Verification (W=16)
REQ-037 Reset, i_any=0, one request -> gnt=1, id=15; next cycle o_busy=0x8000, o_cnt=1.
REQ-038 Reset, i_any=0, 16 back-to-back requests -> ids 15,14,...,0.
- After the 16th: o_full=1, o_cnt=16.
- A 17th request gives gnt=0.
REQ-039 o_busy=0xFFFE, i_any=1, request -> id=0.
- The same cycle's free of id 3 clears bit 3.
- Result: o_busy=0xFFF7, o_cnt unchanged at 15.
REQ-040 Free of id 5 with o_busy[5]=0 -> o_busy and o_cnt unchanged, o_err=1.
- o_err stays 1 through i_flush and clears only on i_arst_n=0.
REQ-041 With o_busy=0x00F0, ptr=6: i_flush with request and free -> gnt=0; next cycle o_busy=0, o_empty=1, ptr=6.
- A following i_any=0 request gives id=5.
REQ-042 i_arst_n asserted asynchronously mid-cycle with o_cnt=9 -> all outputs at reset values before the next clock edge, and o_err=0.

Source files
------------

// File: rtl/slot_alloc_pkg.sv
// ---- slot_alloc_pkg: shared slot-id and occupancy-count types ----
// ---- rev 1.0 ----
`default_nettype none

package slot_alloc_pkg;

  localparam int SLOTS    = 16;
  localparam int SLOT_IW  = $clog2(SLOTS);

  typedef logic [SLOT_IW-1:0] slot_id_t;
  typedef logic [SLOT_IW:0]   slot_cnt_t;

endpackage

`default_nettype wire

// File: rtl/slot_alloc_s.sv
// ---- s: first-zero selector, ascending from 0 or descending with wrap from pos-1 ----
// ---- rev 1.0 ----
`default_nettype none

module s #(
  parameter int W = 16
) (
  input  logic [W-1:0]         i_x,
  input  logic [$clog2(W)-1:0] i_pos,
  input  logic                 i_any,
  output logic [$clog2(W)-1:0] o_y_enc
);

  localparam int IW = $clog2(W);

  logic [IW-1:0] w_idx;

  // Walk from the last candidate back to the first so the earliest hit wins.
  always_comb begin
    o_y_enc = '0;
    w_idx   = '0;
    for (int k = W-1; k >= 0; k--) begin
      w_idx = i_any ? IW'(k) : (i_pos - IW'(1) - IW'(k));
      if (!i_x[w_idx]) o_y_enc = w_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/slot_alloc.sv
// ---- slot_alloc: slot allocator with lowest-free / circular policies, free and flush ----
// ---- rev 1.0 ----
`default_nettype none

module slot_alloc
  import slot_alloc_pkg::*;
#(
  parameter int W = SLOTS
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_any,
  input  logic                 i_alloc_req,
  output logic                 o_alloc_gnt,
  output logic [$clog2(W)-1:0] o_alloc_id,
  input  logic                 i_free_vld,
  input  logic [$clog2(W)-1:0] i_free_id,
  input  logic                 i_flush,
  output logic [W-1:0]         o_busy,
  output logic [$clog2(W):0]   o_cnt,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_err
);

  localparam int            IW       = $clog2(W);
  localparam logic [IW:0]   FULL_CNT = (IW+1)'(W);

  logic [W-1:0]  r_busy;
  logic [IW-1:0] r_ptr;
  logic [IW:0]   r_cnt;
  logic          r_err;

  logic [IW-1:0] w_cand;
  logic          w_full;
  logic          w_gnt;
  logic          w_free_ok;
  logic          w_free_bad;
  logic [W-1:0]  w_set;
  logic [W-1:0]  w_clr;

  s #(.W(W)) u_sel (
    .i_x     (r_busy),
    .i_pos   (r_ptr),
    .i_any   (i_any),
    .o_y_enc (w_cand)
  );

  assign w_full     = (r_cnt == FULL_CNT);
  // Reset gating keeps the grant low while the async reset is held.
  assign w_gnt      = i_arst_n & i_alloc_req & ~w_full & ~i_flush;
  assign w_free_ok  = i_free_vld & ~i_flush &  r_busy[i_free_id];
  assign w_free_bad = i_free_vld & ~i_flush & ~r_busy[i_free_id];
  assign w_set      = w_gnt     ? (W'(1) << w_cand)    : '0;
  assign w_clr      = w_free_ok ? (W'(1) << i_free_id) : '0;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_busy <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_free_bad) r_err <= 1'b1;
      if (w_gnt)      r_ptr <= w_cand;
      if (i_flush) begin
        r_busy <= '0;
        r_cnt  <= '0;
      end else begin
        r_busy <= (r_busy | w_set) & ~w_clr;
        if (w_gnt && !w_free_ok)      r_cnt <= r_cnt + 1'b1;
        else if (!w_gnt && w_free_ok) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_alloc_gnt = w_gnt;
  assign o_alloc_id  = w_cand;
  assign o_busy      = r_busy;
  assign o_cnt       = r_cnt;
  assign o_full      = w_full;
  assign o_empty     = (r_cnt == '0);
  assign o_err       = r_err;

endmodule

`default_nettype wire
